lsu_axil: RTL and testbench
===========================

Name: lsu_axil

Overview:
- Load/store unit between the EXU and data memory.
- Request side: a single valid/ready request port from the EXU.
- Memory side: a full AXI4-Lite master with independent read (AR/R) and write (AW/W/B) channels.
- Generalises the single-channel LSU: parametrised data width, byte/half/word(/dword) sizes, lane alignment, load sign/zero extension, bus error reporting.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, bus and register data width; legal values 32 or 64. OFF_W = log2(DATA_W/8).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  EXU request valid
- req_ready  out  1  LSU can accept a request
- req_wen  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-aligned
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (DATA_W = 64 only)
- req_unsigned  in  1  load zero-extends when 1
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_W  extended load data (0 for stores)
- resp_err  out  1  bus error (resp != OKAY) or misalign trap
- resp_misalign  out  1  misalign trap flag (tied 0 without the optional feature)
- araddr, arvalid, arready, rdata, rresp[1:0], rvalid, rready  AXI-Lite read channel
- awaddr, awvalid, awready, wdata, wstrb[DATA_W/8], wvalid, wready, bresp[1:0], bvalid, bready  AXI-Lite write channel

Behaviour:
- Reset (clk edge with rst = 1): state IDLE; all valid/ready outputs 0 except req_ready = 1; resp_rdata = 0; resp_err = 0.
- Request accept: req_valid & req_ready in IDLE. addr, wdata, size, unsigned and wen are latched; EXU inputs are ignored afterwards.
- req_ready is 1 only in IDLE.
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDRDATA, WR_RESP, RESP.
- Load path:
  - IDLE to RD_ADDR: arvalid = 1, araddr = addr with low OFF_W bits cleared.
  - On arready, go to RD_DATA with rready = 1.
  - On rvalid: data = rdata >> (offset*8), masked to size; sign-extended unless unsigned or size equals the full width. err = (rresp != 0). Go to RESP.
- Store path:
  - IDLE to WR_ADDRDATA: awvalid = wvalid = 1, with the same aligned address.
  - wstrb = ((1 << (1 << size)) - 1) << offset, truncated to DATA_W/8 bits.
  - wdata = req_wdata << (offset*8).
  - AW and W complete independently; each valid drops on its own handshake. Both may complete in the same cycle.
  - After both handshakes, go to WR_RESP with bready = 1.
  - On bvalid: err = (bresp != 0); go to RESP.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. resp_rdata and resp_err are registered and stable while resp_valid = 1.
- Minimum latency from accept to resp_valid: load 3 cycles, store 3 cycles, zero-wait slave.
- AXI valids stay asserted until their handshake; no address or data change while valid is pending.
- rvalid/bvalid arriving outside RD_DATA/WR_RESP are ignored; the slave must not do this.
- rst asserted mid-transaction aborts to IDLE immediately. Any outstanding AXI beat is dropped; the bench resets the slave with the LSU.
- Without the optional feature, misaligned accesses are not trapped: bytes beyond the bus width are silently dropped from wstrb and load data.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- When defined: at accept, if addr is not a multiple of (1 << size), no AXI transaction is issued. The LSU goes straight to RESP; resp_valid arrives 1 cycle after accept with resp_err = 1, resp_misalign = 1, resp_rdata = 0.
- When undefined: the check logic is absent and resp_misalign is constant 0.

Decomposition:
- Shared package lsu_pkg:
  - size encodings (SZ_B/H/W/D);
  - AXI resp codes (OKAY = 0, SLVERR = 2, DECERR = 3);
  - state enum.
- One sub-module, lsu_lane_align (combinational):
  - store shift and strobe generation;
  - load shift and extension.
- The FSM stays in lsu_axil.

Test Plan:
- lb, DATA_W = 32, addr 0x8000_0003, rdata 0x80FF_FF11, zero-wait slave -> araddr 0x8000_0000; resp_rdata 0xFFFF_FF80, resp_valid 3 cycles after accept.
- lhu, addr 0x8000_0002, rdata 0xBEEF_1234 -> resp_rdata 0x0000_BEEF, resp_err 0.
- sb, addr 0x8000_0001, wdata 0x0000_00AB, awready 2 cycles later than wready -> wstrb 4'b0010, wdata 0x0000_AB00. Both valids drop independently; resp_valid after bvalid.
- sw with bresp = 2'b10 -> resp_err 1. lw with rresp = 2'b11 -> resp_err 1.
- rst pulsed while in RD_DATA -> next cycle req_ready 1, rready 0, arvalid 0. The next load completes normally.
- LSU_MISALIGN_CHECK_EN, lw at 0x8000_0002 -> no arvalid ever; resp_valid 1 cycle after accept with resp_err = resp_misalign = 1.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings for the AXI4-Lite load/store unit
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE        = 3'd0;
  localparam state_t ST_RD_ADDR     = 3'd1;
  localparam state_t ST_RD_DATA     = 3'd2;
  localparam state_t ST_WR_ADDRDATA = 3'd3;
  localparam state_t ST_WR_RESP     = 3'd4;
  localparam state_t ST_RESP        = 3'd5;

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane placement for stores and lane extraction/extension for loads
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [OFF_W-1:0]    i_offset,
  input  logic [1:0]          i_size,
  input  logic                i_unsigned,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W-1:0]   i_rdata,
  output logic [DATA_W-1:0]   o_wdata,
  output logic [DATA_W/8-1:0] o_wstrb,
  output logic [DATA_W-1:0]   o_rdata
);

  localparam int STRB_W = DATA_W / 8;

  logic [7:0]          w_strb_base;
  logic [15:0]         w_strb_wide;
  logic [3:0]          w_nbytes;
  logic [6:0]          w_lsh;
  logic [DATA_W-1:0]   w_rshift;
  logic [DATA_W-1:0]   w_left;
  logic signed [DATA_W-1:0] w_left_s;
  logic [DATA_W-1:0]   w_sext;
  logic [DATA_W-1:0]   w_zext;

  always_comb begin
    w_strb_base = 8'h01;
    w_nbytes    = 4'd1;
    case (i_size)
      SZ_B: begin w_strb_base = 8'h01; w_nbytes = 4'd1; end
      SZ_H: begin w_strb_base = 8'h03; w_nbytes = 4'd2; end
      SZ_W: begin w_strb_base = 8'h0F; w_nbytes = 4'd4; end
      SZ_D: begin w_strb_base = 8'hFF; w_nbytes = 4'(STRB_W); end
      default: begin w_strb_base = 8'h01; w_nbytes = 4'd1; end
    endcase
  end

  // Lanes shifted past the bus width fall off the top and are dropped.
  assign w_strb_wide = {8'h00, w_strb_base} << i_offset;
  assign o_wstrb     = w_strb_wide[STRB_W-1:0];
  assign o_wdata     = i_wdata << {i_offset, 3'b000};

  // Park the field at the top of the word, then shift back down to extend it.
  assign w_rshift = i_rdata >> {i_offset, 3'b000};
  assign w_lsh    = 7'(DATA_W) - {w_nbytes, 3'b000};
  assign w_left   = w_rshift << w_lsh;
  assign w_left_s = w_left;
  assign w_sext   = w_left_s >>> w_lsh;
  assign w_zext   = w_left >> w_lsh;
  assign o_rdata  = i_unsigned ? w_zext : w_sext;

endmodule

// File: rtl/lsu_axil.sv
// rtl/lsu_axil.sv - load/store unit with AXI4-Lite master; optional LSU_MISALIGN_CHECK_EN traps misaligned accesses
module lsu_axil
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_wen,
  input  logic [ADDR_W-1:0]   i_req_addr,
  input  logic [DATA_W-1:0]   i_req_wdata,
  input  logic [1:0]          i_req_size,
  input  logic                i_req_unsigned,
  output logic                o_resp_valid,
  output logic [DATA_W-1:0]   o_resp_rdata,
  output logic                o_resp_err,
  output logic                o_resp_misalign,
  output logic [ADDR_W-1:0]   o_araddr,
  output logic                o_arvalid,
  input  logic                i_arready,
  input  logic [DATA_W-1:0]   i_rdata,
  input  logic [1:0]          i_rresp,
  input  logic                i_rvalid,
  output logic                o_rready,
  output logic [ADDR_W-1:0]   o_awaddr,
  output logic                o_awvalid,
  input  logic                i_awready,
  output logic [DATA_W-1:0]   o_wdata,
  output logic [DATA_W/8-1:0] o_wstrb,
  output logic                o_wvalid,
  input  logic                i_wready,
  input  logic [1:0]          i_bresp,
  input  logic                i_bvalid,
  output logic                o_bready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic                r_aw_done;
  logic                r_w_done;
  logic [DATA_W-1:0]   r_resp_rdata;
  logic                r_resp_err;

  logic                w_misalign;
  logic                w_aw_hs;
  logic                w_w_hs;
  logic [DATA_W-1:0]   w_load_data;

  lsu_lane_align #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_align (
    .i_offset   (r_addr[OFF_W-1:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_wdata    (r_wdata),
    .i_rdata    (i_rdata),
    .o_wdata    (o_wdata),
    .o_wstrb    (o_wstrb),
    .o_rdata    (w_load_data)
  );

`ifdef LSU_MISALIGN_CHECK_EN
  logic [2:0] w_amask;
  logic       r_resp_mis;

  always_comb begin
    w_amask = 3'b000;
    case (i_req_size)
      SZ_B:    w_amask = 3'b000;
      SZ_H:    w_amask = 3'b001;
      SZ_W:    w_amask = 3'b011;
      SZ_D:    w_amask = 3'b111;
      default: w_amask = 3'b000;
    endcase
  end

  assign w_misalign = |(i_req_addr[2:0] & w_amask);

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_resp_mis <= 1'b0;
    else if (r_state == ST_IDLE && i_req_valid)
      r_resp_mis <= w_misalign;
  end

  assign o_resp_misalign = r_resp_mis;
`else
  assign w_misalign      = 1'b0;
  assign o_resp_misalign = 1'b0;
`endif

  assign o_req_ready  = (r_state == ST_IDLE);
  assign o_arvalid    = (r_state == ST_RD_ADDR);
  assign o_rready     = (r_state == ST_RD_DATA);
  assign o_awvalid    = (r_state == ST_WR_ADDRDATA) && !r_aw_done;
  assign o_wvalid     = (r_state == ST_WR_ADDRDATA) && !r_w_done;
  assign o_bready     = (r_state == ST_WR_RESP);
  assign o_resp_valid = (r_state == ST_RESP);
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;

  assign o_araddr = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign o_awaddr = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  assign w_aw_hs = o_awvalid && i_awready;
  assign w_w_hs  = o_wvalid && i_wready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_size       <= SZ_B;
      r_unsigned   <= 1'b0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_addr       <= i_req_addr;
            r_wdata      <= i_req_wdata;
            r_size       <= i_req_size;
            r_unsigned   <= i_req_unsigned;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= w_misalign;
            if (w_misalign)
              r_state <= ST_RESP;
            else
              r_state <= i_req_wen ? ST_WR_ADDRDATA : ST_RD_ADDR;
          end
        end
        ST_RD_ADDR: begin
          if (i_arready) r_state <= ST_RD_DATA;
        end
        ST_RD_DATA: begin
          if (i_rvalid) begin
            r_resp_rdata <= w_load_data;
            r_resp_err   <= (i_rresp != RESP_OKAY);
            r_state      <= ST_RESP;
          end
        end
        ST_WR_ADDRDATA: begin
          // AW and W retire independently; leave once both have been taken.
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
          if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs))
            r_state <= ST_WR_RESP;
        end
        ST_WR_RESP: begin
          if (i_bvalid) begin
            r_resp_err <= (i_bresp != RESP_OKAY);
            r_state    <= ST_RESP;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_axil.sv
// tb/tb_lsu_axil.sv - directed self-checking bench for lsu_axil acting as the AXI-Lite slave
module tb_lsu_axil;
  import lsu_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        resp_misalign;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int n_cmp  = 0;
  int n_fail = 0;

  lsu_axil #(.ADDR_W(32), .DATA_W(32)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_wen      (req_wen),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .i_req_size     (req_size),
    .i_req_unsigned (req_unsigned),
    .o_resp_valid   (resp_valid),
    .o_resp_rdata   (resp_rdata),
    .o_resp_err     (resp_err),
    .o_resp_misalign(resp_misalign),
    .o_araddr       (araddr),
    .o_arvalid      (arvalid),
    .i_arready      (arready),
    .i_rdata        (rdata),
    .i_rresp        (rresp),
    .i_rvalid       (rvalid),
    .o_rready       (rready),
    .o_awaddr       (awaddr),
    .o_awvalid      (awvalid),
    .i_awready      (awready),
    .o_wdata        (wdata),
    .o_wstrb        (wstrb),
    .o_wvalid       (wvalid),
    .i_wready       (wready),
    .i_bresp        (bresp),
    .i_bvalid       (bvalid),
    .o_bready       (bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wd);
    @(negedge clk);
    check("accept_ready", req_ready, 1'b1);
    req_valid    = 1'b1;
    req_wen      = wen;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wd;
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input int ar_dly, input int r_dly,
                         input logic [31:0] rd, input logic [1:0] rr,
                         input logic [31:0] exp_data, input logic exp_err);
    accept(1'b0, addr, size, uns, 32'h0);
    for (int k = 0; k <= ar_dly; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = 32'hFFFF_FFFF;
      check({tag, "_arvalid"}, arvalid, 1'b1);
      check({tag, "_araddr"}, araddr, {addr[31:2], 2'b00});
      check({tag, "_rdy_busy"}, req_ready, 1'b0);
      arready = (k == ar_dly);
    end
    for (int k = 0; k <= r_dly; k++) begin
      @(negedge clk);
      arready = 1'b0;
      check({tag, "_rready"}, rready, 1'b1);
      check({tag, "_ar_drop"}, arvalid, 1'b0);
      rvalid = (k == r_dly);
      rdata  = rd;
      rresp  = rr;
    end
    @(negedge clk);
    rvalid = 1'b0;
    rdata  = 32'h0;
    rresp  = RESP_OKAY;
    check({tag, "_resp_valid"}, resp_valid, 1'b1);
    check({tag, "_rdata"}, resp_rdata, exp_data);
    check({tag, "_err"}, resp_err, exp_err);
    @(negedge clk);
    check({tag, "_resp_pulse"}, resp_valid, 1'b0);
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] wd, input int aw_dly, input int w_dly,
                          input logic [1:0] br, input logic [31:0] exp_wdata,
                          input logic [3:0] exp_strb, input logic exp_err);
    int last;
    last = (aw_dly > w_dly) ? aw_dly : w_dly;
    accept(1'b1, addr, size, 1'b0, wd);
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      req_wdata = 32'h5555_5555;
      check({tag, "_awvalid"}, awvalid, k <= aw_dly);
      check({tag, "_wvalid"}, wvalid, k <= w_dly);
      if (k <= aw_dly) check({tag, "_awaddr"}, awaddr, {addr[31:2], 2'b00});
      if (k <= w_dly) begin
        check({tag, "_wdata"}, wdata, exp_wdata);
        check({tag, "_wstrb"}, wstrb, exp_strb);
      end
      awready = (k == aw_dly);
      wready  = (k == w_dly);
    end
    @(negedge clk);
    awready = 1'b0;
    wready  = 1'b0;
    check({tag, "_bready"}, bready, 1'b1);
    check({tag, "_aw_drop"}, awvalid, 1'b0);
    check({tag, "_w_drop"}, wvalid, 1'b0);
    bvalid = 1'b1;
    bresp  = br;
    @(negedge clk);
    bvalid = 1'b0;
    bresp  = RESP_OKAY;
    check({tag, "_resp_valid"}, resp_valid, 1'b1);
    check({tag, "_rdata0"}, resp_rdata, 32'h0);
    check({tag, "_err"}, resp_err, exp_err);
    @(negedge clk);
    check({tag, "_resp_pulse"}, resp_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = SZ_B; req_unsigned = 1'b0;
    arready = 1'b0; rdata = '0; rresp = RESP_OKAY; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = RESP_OKAY; bvalid = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_req_ready", req_ready, 1'b1);
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_wvalid", wvalid, 1'b0);
    check("rst_bready", bready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", resp_err, 1'b0);
    check("rst_misalign", resp_misalign, 1'b0);
    rst = 1'b0;

    do_load("lb", 32'h8000_0003, SZ_B, 1'b0, 0, 0, 32'h80FF_FF11, RESP_OKAY, 32'hFFFF_FF80, 1'b0);
    do_load("lhu", 32'h8000_0002, SZ_H, 1'b1, 0, 0, 32'hBEEF_1234, RESP_OKAY, 32'h0000_BEEF, 1'b0);
    do_load("lh", 32'h8000_0000, SZ_H, 1'b0, 1, 2, 32'h1234_F00D, RESP_OKAY, 32'hFFFF_F00D, 1'b0);
    do_load("lbu", 32'h8000_0001, SZ_B, 1'b1, 0, 0, 32'h0000_8100, RESP_OKAY, 32'h0000_0081, 1'b0);
    do_load("lb_pos", 32'h8000_0001, SZ_B, 1'b0, 0, 0, 32'h0000_7F00, RESP_OKAY, 32'h0000_007F, 1'b0);
    do_load("lw_decerr", 32'h8000_0008, SZ_W, 1'b0, 0, 0, 32'hDEAD_BEEF, RESP_DECERR, 32'hDEAD_BEEF, 1'b1);

    do_store("sb", 32'h8000_0001, SZ_B, 32'h0000_00AB, 2, 0, RESP_OKAY, 32'h0000_AB00, 4'b0010, 1'b0);
    do_store("sh", 32'h8000_0002, SZ_H, 32'h0000_CAFE, 0, 1, RESP_OKAY, 32'hCAFE_0000, 4'b1100, 1'b0);
    do_store("sw_slverr", 32'h8000_0004, SZ_W, 32'h1234_5678, 0, 0, RESP_SLVERR, 32'h1234_5678, 4'b1111, 1'b1);
    do_store("sb_same", 32'h8000_0003, SZ_B, 32'h0000_00C3, 1, 1, RESP_OKAY, 32'hC300_0000, 4'b1000, 1'b0);

    // Abort a load while it waits for read data.
    accept(1'b0, 32'h8000_0010, SZ_W, 1'b0, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_arvalid", arvalid, 1'b1);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    check("abort_in_rd_data", rready, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_req_ready", req_ready, 1'b1);
    check("abort_rready", rready, 1'b0);
    check("abort_arvalid0", arvalid, 1'b0);
    check("abort_resp_valid", resp_valid, 1'b0);
    do_load("lw_after_rst", 32'h8000_0010, SZ_W, 1'b0, 0, 0, 32'hA5A5_0F0F, RESP_OKAY, 32'hA5A5_0F0F, 1'b0);

`ifdef LSU_MISALIGN_CHECK_EN
    accept(1'b0, 32'h8000_0002, SZ_W, 1'b0, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    check("mis_arvalid", arvalid, 1'b0);
    check("mis_resp_valid", resp_valid, 1'b1);
    check("mis_err", resp_err, 1'b1);
    check("mis_flag", resp_misalign, 1'b1);
    check("mis_rdata", resp_rdata, 32'h0);
    @(negedge clk);
    check("mis_arvalid2", arvalid, 1'b0);
    check("mis_pulse", resp_valid, 1'b0);
    check("mis_ready", req_ready, 1'b1);
    do_load("lw_aligned", 32'h8000_0004, SZ_W, 1'b0, 0, 0, 32'h0BAD_F00D, RESP_OKAY, 32'h0BAD_F00D, 1'b0);
    check("mis_flag_clear", resp_misalign, 1'b0);
`else
    do_load("lw_unaligned", 32'h8000_0002, SZ_W, 1'b0, 0, 0, 32'hAABB_CCDD, RESP_OKAY, 32'h0000_AABB, 1'b0);
    check("no_trap_flag", resp_misalign, 1'b0);
    do_store("sw_unaligned", 32'h8000_0003, SZ_W, 32'h1122_3344, 0, 0, RESP_OKAY, 32'h4400_0000, 4'b1000, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
